// File: rtl/p405s_icu_dp_regq_vb4.sv
// rtl/p405s_icu_dp_regq_vb4.sv - small circular register queue with registered head output
//
// Purpose:
//   DEPTH-entry FIFO of WIDTH-bit words. The write and read pointers wrap at
//   DEPTH-1. The head word is presented on L2 from storage and never from D.
//   When the queue is empty, L2 shows either the last head value (HOLD_LAST=1)
//   or zero (HOLD_LAST=0).
//
// Ports:
//   CB     in   clock, rising edge
//   RB     in   asynchronous active-low reset
//   D      in   [0:WIDTH-1] write data, bit 0 is the MSB
//   E1     in   push request
//   RD     in   pop request
//   FLUSH  in   synchronous clear of count, pointers and OVF
//   L2     out  [0:WIDTH-1] head data
//   VLD    out  queue non-empty
//   FULL   out  count equals DEPTH
//   CNT    out  number of valid entries
//   OVF    out  sticky rejected-push flag

module p405s_icu_dp_regq_vb4 #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int HOLD_LAST = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             CB,
  input  logic             RB,
  input  logic [0:WIDTH-1] D,
  input  logic             E1,
  input  logic             RD,
  input  logic             FLUSH,
  output logic [0:WIDTH-1] L2,
  output logic             VLD,
  output logic             FULL,
  output logic [CW-1:0]    CNT,
  output logic             OVF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

  logic [0:WIDTH-1] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [0:WIDTH-1] r_hold;

  logic             w_vld;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_reject;
  logic [0:WIDTH-1] w_head;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign w_vld    = (r_cnt != '0);
  assign w_full   = (r_cnt == CNT_MAX);
  assign w_head   = r_mem[r_rptr];
  // A full queue still accepts a push when a pop frees the head slot in the
  // same edge; an empty queue ignores the pop half of a push+pop.
  assign w_pop    = RD & w_vld;
  assign w_push   = E1 & (~w_full | RD);
  assign w_reject = E1 & w_full & ~RD;

  // Entry storage carries no reset: nothing reaches L2 unless VLD says it was written.
  always_ff @(posedge CB) begin
    if (w_push && !FLUSH) begin
      r_mem[r_wptr] <= D;
    end
  end

  always_ff @(posedge CB or negedge RB) begin
    if (!RB) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_hold <= '0;
    end else if (FLUSH) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      // Capture what L2 was showing so an empty queue keeps presenting it.
      if (w_vld) begin
        r_hold <= w_head;
      end
    end else begin
      if (w_push) begin
        r_wptr <= f_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // Last entry leaving: remember it for the HOLD_LAST view.
      if (w_pop && !w_push && (r_cnt == CW'(1))) begin
        r_hold <= w_head;
      end
      if (w_reject) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign VLD  = w_vld;
  assign FULL = w_full;
  assign CNT  = r_cnt;
  assign OVF  = r_ovf;
  assign L2   = w_vld ? w_head : ((HOLD_LAST != 0) ? r_hold : '0);

endmodule

// File: tb/tb_p405s_icu_dp_regq_vb4.sv
// tb/tb_p405s_icu_dp_regq_vb4.sv - self-checking bench for p405s_icu_dp_regq_vb4

module tb_p405s_icu_dp_regq_vb4;

  logic        CB = 1'b0;
  logic        RB = 1'b0;
  logic [0:31] D  = '0;
  logic        E1 = 1'b0;
  logic        RD = 1'b0;
  logic        FLUSH = 1'b0;

  always #5 CB = ~CB;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [0:31] l2_0, l2_1, l2_2, l2_3;
  logic        vld_0, vld_1, vld_2, vld_3;
  logic        full_0, full_1, full_2, full_3;
  logic        ovf_0, ovf_1, ovf_2, ovf_3;
  logic [2:0]  cnt_0, cnt_1;
  logic [1:0]  cnt_2;
  logic [0:0]  cnt_3;

  // u0: depth 4 hold-last, u1: depth 4 zero-when-empty, u2: depth 3, u3: depth 1 with RD tied to E1
  p405s_icu_dp_regq_vb4 #(.WIDTH(32), .DEPTH(4), .HOLD_LAST(1)) u0 (
    .CB(CB), .RB(RB), .D(D), .E1(E1), .RD(RD), .FLUSH(FLUSH),
    .L2(l2_0), .VLD(vld_0), .FULL(full_0), .CNT(cnt_0), .OVF(ovf_0));
  p405s_icu_dp_regq_vb4 #(.WIDTH(32), .DEPTH(4), .HOLD_LAST(0)) u1 (
    .CB(CB), .RB(RB), .D(D), .E1(E1), .RD(RD), .FLUSH(FLUSH),
    .L2(l2_1), .VLD(vld_1), .FULL(full_1), .CNT(cnt_1), .OVF(ovf_1));
  p405s_icu_dp_regq_vb4 #(.WIDTH(32), .DEPTH(3), .HOLD_LAST(1)) u2 (
    .CB(CB), .RB(RB), .D(D), .E1(E1), .RD(RD), .FLUSH(FLUSH),
    .L2(l2_2), .VLD(vld_2), .FULL(full_2), .CNT(cnt_2), .OVF(ovf_2));
  p405s_icu_dp_regq_vb4 #(.WIDTH(32), .DEPTH(1), .HOLD_LAST(1)) u3 (
    .CB(CB), .RB(RB), .D(D), .E1(E1), .RD(E1), .FLUSH(FLUSH),
    .L2(l2_3), .VLD(vld_3), .FULL(full_3), .CNT(cnt_3), .OVF(ovf_3));

  // Reference model: an ordered list per instance with the head at index 0.
  int          dep [4] = '{4, 4, 3, 1};
  bit          hl  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] md  [4][16];
  int          mc  [4];
  bit          mo  [4];
  logic [31:0] mh  [4];

  always @(posedge CB or negedge RB) begin
    if (!RB) begin
      for (int k = 0; k < 4; k++) begin
        mc[k] <= 0;
        mo[k] <= 1'b0;
        mh[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        bit rdk;
        bit isfull;
        bit pop;
        bit push;
        rdk    = (k == 3) ? E1 : RD;
        isfull = (mc[k] == dep[k]);
        pop    = rdk && (mc[k] > 0);
        push   = E1 && (!isfull || rdk);
        if (FLUSH) begin
          if (mc[k] > 0) mh[k] <= md[k][0];
          mc[k] <= 0;
          mo[k] <= 1'b0;
        end else begin
          if (E1 && isfull && !rdk) mo[k] <= 1'b1;
          if (pop && !push && mc[k] == 1) mh[k] <= md[k][0];
          if (pop) begin
            for (int j = 0; j < 15; j++) md[k][j] <= md[k][j+1];
          end
          if (push) md[k][mc[k] - (pop ? 1 : 0)] <= D;
          mc[k] <= mc[k] + (push ? 1 : 0) - (pop ? 1 : 0);
        end
      end
    end
  end

  function automatic logic [31:0] exp_l2(input int k);
    if (mc[k] > 0) return md[k][0];
    return hl[k] ? mh[k] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] l2, input logic vld,
                          input logic full, input logic [63:0] cnt, input logic ovf);
    chk($sformatf("u%0d.L2", k),   l2,   exp_l2(k));
    chk($sformatf("u%0d.VLD", k),  vld,  mc[k] != 0);
    chk($sformatf("u%0d.FULL", k), full, mc[k] == dep[k]);
    chk($sformatf("u%0d.CNT", k),  cnt,  mc[k]);
    chk($sformatf("u%0d.OVF", k),  ovf,  mo[k]);
  endtask

  always @(negedge CB) begin
    if (chk_en) begin
      cmp_inst(0, l2_0, vld_0, full_0, cnt_0, ovf_0);
      cmp_inst(1, l2_1, vld_1, full_1, cnt_1, ovf_1);
      cmp_inst(2, l2_2, vld_2, full_2, cnt_2, ovf_2);
      cmp_inst(3, l2_3, vld_3, full_3, cnt_3, ovf_3);
    end
  end

  task automatic step(input bit e, input bit r, input bit f, input logic [31:0] d);
    E1 = e; RD = r; FLUSH = f; D = d;
    @(posedge CB);
    #1;
  endtask

  task automatic lit_u0(input string tag, input logic [31:0] l2, input bit v,
                        input bit fu, input int c, input bit o);
    chk({tag, ".L2"},   l2_0,   l2);
    chk({tag, ".VLD"},  vld_0,  v);
    chk({tag, ".FULL"}, full_0, fu);
    chk({tag, ".CNT"},  cnt_0,  c);
    chk({tag, ".OVF"},  ovf_0,  o);
  endtask

  initial begin
    RB = 1'b0;
    repeat (2) @(posedge CB);
    #1;
    lit_u0("reset", 32'h0, 0, 0, 0, 0);
    RB = 1'b1;
    chk_en = 1'b1;

    // Four consecutive pushes then drain
    step(1, 0, 0, 32'h11111111);
    step(1, 0, 0, 32'h22222222);
    step(1, 0, 0, 32'h33333333);
    step(1, 0, 0, 32'h44444444);
    lit_u0("fill4", 32'h11111111, 1, 1, 4, 0);
    step(0, 1, 0, 32'h0);
    lit_u0("pop1", 32'h22222222, 1, 0, 3, 0);
    step(0, 1, 0, 32'h0);
    lit_u0("pop2", 32'h33333333, 1, 0, 2, 0);
    step(0, 1, 0, 32'h0);
    lit_u0("pop3", 32'h44444444, 1, 0, 1, 0);
    step(0, 1, 0, 32'h0);
    lit_u0("pop4", 32'h44444444, 0, 0, 0, 0);
    chk("u1.drained_L2", l2_1, 32'h0);
    chk("u2.ovf_after_4_pushes", ovf_2, 1'b1);

    // Full queue: rejected push, then push with pop
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 32'h01010101 * i);
    step(1, 0, 0, 32'hDEADBEEF);
    lit_u0("reject", 32'h01010101, 1, 1, 4, 1);
    step(1, 1, 0, 32'hDEADBEEF);
    lit_u0("full_pushpop", 32'h02020202, 1, 1, 4, 1);

    // Down to two entries with OVF set, then FLUSH together with a push
    step(0, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    lit_u0("cnt2_ovf", 32'h04040404, 1, 0, 2, 1);
    step(1, 0, 1, 32'h55555555);
    lit_u0("flush", 32'h04040404, 0, 0, 0, 0);
    chk("u1.flush_L2", l2_1, 32'h0);

    // Push and pop on an empty queue
    step(1, 1, 0, 32'hA5A5A5A5);
    lit_u0("empty_pushpop", 32'hA5A5A5A5, 1, 0, 1, 0);
    chk("u1.empty_pushpop_L2", l2_1, 32'hA5A5A5A5);
    chk("u3.reg_L2", l2_3, 32'hA5A5A5A5);
    step(1, 1, 0, 32'h5A5A5A5A);
    chk("u3.reg_L2_next", l2_3, 32'h5A5A5A5A);
    step(0, 1, 0, 32'h0);
    lit_u0("empty_drain", 32'h5A5A5A5A, 0, 0, 0, 0);
    chk("u1.drain_zero", l2_1, 32'h0);

    // Mixed push/pop pattern with pointer wrap in every depth
    for (int i = 0; i < 30; i++) begin
      step((i % 3) != 2, (i % 4 == 1) || (i % 4 == 2), 1'b0, 32'h10000000 + i * 32'h0101);
    end

    // Asynchronous reset between edges with three entries held
    step(1, 0, 1, 32'h0);
    step(1, 0, 0, 32'hC0000001);
    step(1, 0, 0, 32'hC0000002);
    step(1, 0, 0, 32'hC0000003);
    E1 = 1'b0;
    lit_u0("pre_reset", 32'hC0000001, 1, 0, 3, 0);
    #2;
    RB = 1'b0;
    #1;
    lit_u0("async_reset", 32'h0, 0, 0, 0, 0);
    chk("u2.async_L2", l2_2, 32'h0);
    chk("u2.async_CNT", cnt_2, 2'd0);
    @(posedge CB);
    #1;
    RB = 1'b1;
    step(1, 0, 0, 32'h77777777);
    lit_u0("after_reset", 32'h77777777, 1, 0, 1, 0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);

    @(negedge CB);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p405s_icu_dp_regq_vb4.md
P405S_ICU_DP_REGQ_VB4 -- requirements
Module: p405s_icu_dp_regQ_vb4

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register entries; legal range 1..16, any integer (not restricted to powers of two).
REQ-003 Parameter HOLD_LAST, default 1: 1 = L2 holds the last head value when the queue is empty; 0 = L2 is forced to all-zero when empty.
REQ-004 CB  input  1  clock; all state is updated on its rising edge.
REQ-005 RB  input  1  reset; asynchronous, active-low.
REQ-006 D  input  [0:WIDTH-1]  write data; bit 0 is the MSB.
REQ-007 E1  input  1  push request; D is captured at the edge when accepted.
REQ-008 RD  input  1  pop request; removes the head entry when accepted.
REQ-009 FLUSH  input  1  synchronous clear of queue contents.
REQ-010 L2  output  [0:WIDTH-1]  head-entry data, driven directly from a register or mux (no combinational path from D).
REQ-011 VLD  output  1  queue non-empty.
REQ-012 FULL  output  1  count equals DEPTH.
REQ-013 CNT  output  [clog2(DEPTH+1)-1:0]  number of valid entries.
REQ-014 OVF  output  1  sticky flag, set by a rejected push.

Function
REQ-015 Storage: DEPTH entries of WIDTH bits, circular write and read pointers; each pointer wraps from DEPTH-1 to 0.
REQ-016 Push acceptance: E1=1 and (FULL=0 or RD=1); an accepted push writes D at the write pointer, then advances the pointer.
REQ-017 Pop acceptance: RD=1 and VLD=1; an accepted pop advances the read pointer; RD while empty is ignored with no error.
REQ-018 Latency: data pushed at edge N appears on L2 after edge N when the queue was empty; there is no same-cycle bypass.
REQ-019 Simultaneous push and pop while empty: push accepted, pop ignored; CNT becomes 1.
REQ-020 Simultaneous push and pop while FULL: both accepted; CNT unchanged; FULL stays 1; the new data goes to the freed slot.
REQ-021 Simultaneous push and pop otherwise: both accepted; CNT unchanged.
REQ-022 CNT update: increments on push only, decrements on pop only; never exceeds DEPTH and never underflows.
REQ-023 Rejected push: E1=1, FULL=1, RD=0; storage and pointers are unchanged; OVF is set to 1 at that edge.
REQ-024 OVF: cleared only by reset or FLUSH; a rejected push in the same cycle as FLUSH does not set it.
REQ-025 FLUSH: has priority over E1 and RD; at the edge, CNT=0, both pointers=0 and OVF=0; entry contents are not cleared.
REQ-026 L2 when VLD=1: the entry at the read pointer.
REQ-027 L2 when VLD=0 and HOLD_LAST=1: the value L2 had when the last entry left, by pop or by FLUSH.
REQ-028 L2 when VLD=0 and HOLD_LAST=0: all zeros.
REQ-029 VLD = (CNT != 0); FULL = (CNT == DEPTH); both are decoded from registered CNT.
REQ-030 DEPTH=1, HOLD_LAST=1 with RD tied to E1: equivalent to a plain enabled register; L2 updates with D on every edge where E1=1.

Reset
REQ-031 RB=0 asynchronously forces: pointers=0, CNT=0, VLD=0, FULL=0, OVF=0, L2=0 (the held-last value is also cleared to 0).
REQ-032 Storage-entry contents need no reset; no entry contents reach L2 before they are written.
REQ-033 Reset asserted mid-operation discards all entries; the first edge after RB deasserts behaves as an empty queue.
REQ-034 RB deassertion is assumed synchronised externally; the block adds no reset synchroniser.

Verification
REQ-035 DEPTH=4: push 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive edges -> CNT=4, FULL=1, L2=0x11111111; then 4 pops -> L2 sequence 0x22222222, 0x33333333, 0x44444444, then hold at 0x44444444 with VLD=0.
REQ-036 Full queue: push 0xDEADBEEF with RD=0 -> OVF=1, CNT stays 4, contents unchanged; same stimulus with RD=1 -> head pops, 0xDEADBEEF is enqueued, CNT=4, OVF unchanged.
REQ-037 Empty queue: E1=1 and RD=1 with D=0xA5A5A5A5 -> after the edge CNT=1, L2=0xA5A5A5A5; repeat with HOLD_LAST=0 and the queue then drained -> L2=0.
REQ-038 DEPTH=3: 10 push/pop cycles with pointer wrap -> FIFO order preserved against a reference model; CNT never exceeds 3.
REQ-039 CNT=2 with OVF=1: FLUSH together with E1=1 -> CNT=0, OVF=0, VLD=0.
REQ-040 Async reset: drop RB between edges with CNT=3 -> all outputs reach reset values before the next CB edge.
